// File: rtl/ddr_frame_pkg.sv
// Shared definitions for the DDR frame read/write controllers.
// Holds the FSM state encoding, default geometry and burst port widths.
package ddr_frame_pkg;

  localparam int DEF_BANK_W       = 2;
  localparam int DEF_OFF_W        = 22;
  localparam int DEF_BURST_LEN    = 64;
  localparam int DEF_FRAME_BURSTS = 12288;
  localparam int DEF_FIFO_AW      = 9;

  // Width of the burst length field on the DDR burst port
  localparam int BURST_LEN_W      = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } frame_state_e;

endpackage

// File: rtl/frame_read_ctrl_if.sv
// Bundle of the bank-switcher, DDR burst-read and FIFO-write signals
// seen by the frame read controller. The controller uses the master
// modport; the surrounding system (or a bench) uses the slave modport.
interface frame_read_ctrl_if #(
  parameter int BANK_W  = ddr_frame_pkg::DEF_BANK_W,
  parameter int OFF_W   = ddr_frame_pkg::DEF_OFF_W,
  parameter int FIFO_AW = ddr_frame_pkg::DEF_FIFO_AW
);
  import ddr_frame_pkg::*;

  // bank switcher side
  logic                    rd_load;
  logic [BANK_W-1:0]       rd_bank;
  logic                    frame_read_done;

  // DDR burst read port
  logic                    rd_burst_req;
  logic [BANK_W+OFF_W-1:0] rd_burst_addr;
  logic [BURST_LEN_W-1:0]  rd_burst_len;
  logic                    rd_burst_ack;
  logic                    rd_burst_data_valid;
  logic                    rd_burst_finish;

  // LCD line FIFO write side
  logic [FIFO_AW-1:0]      fifo_wr_level;
  logic                    fifo_wr_en;

  modport master (
    input  rd_load,
    input  rd_bank,
    input  fifo_wr_level,
    input  rd_burst_ack,
    input  rd_burst_data_valid,
    input  rd_burst_finish,
    output rd_burst_req,
    output rd_burst_addr,
    output rd_burst_len,
    output fifo_wr_en,
    output frame_read_done
  );

  modport slave (
    output rd_load,
    output rd_bank,
    output fifo_wr_level,
    output rd_burst_ack,
    output rd_burst_data_valid,
    output rd_burst_finish,
    input  rd_burst_req,
    input  rd_burst_addr,
    input  rd_burst_len,
    input  fifo_wr_en,
    input  frame_read_done
  );

endinterface

// File: rtl/frame_read_ctrl.sv
// Frame read controller: walks one whole frame out of the selected DDR
// bank as fixed-length bursts into the LCD line FIFO, only asking for a
// burst once the FIFO can absorb all of it. A new frame load arriving
// while a burst is in flight is parked and applied when that burst ends,
// so a request is never withdrawn from the DDR port.
module frame_read_ctrl
  import ddr_frame_pkg::*;
#(
  parameter int BANK_W       = DEF_BANK_W,
  parameter int OFF_W        = DEF_OFF_W,
  parameter int BURST_LEN    = DEF_BURST_LEN,
  parameter int FRAME_BURSTS = DEF_FRAME_BURSTS,
  parameter int FIFO_AW      = DEF_FIFO_AW
) (
  input  logic              clk,
  input  logic              rst,
  frame_read_ctrl_if.master bus
);

  localparam int CNT_W  = $clog2(FRAME_BURSTS + 1);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  // FIFO must have at least BURST_LEN free words before a burst is requested
  localparam logic [FIFO_AW:0]     FIFO_THRESH = (FIFO_AW+1)'((1 << FIFO_AW) - BURST_LEN);
  localparam logic [OFF_W-1:0]     OFF_STEP    = OFF_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]     LAST_BURST  = CNT_W'(FRAME_BURSTS - 1);
  localparam logic [BEAT_W-1:0]    BEAT_MAX    = BEAT_W'(BURST_LEN);

  frame_state_e         state_q, state_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [OFF_W-1:0]     offset_q, offset_d;
  logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic                 load_pend_q, load_pend_d;
  logic [BANK_W-1:0]    pend_bank_q, pend_bank_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                 wr_en_q;
  logic                 fifo_has_room;

  assign fifo_has_room = ({1'b0, bus.fifo_wr_level} <= FIFO_THRESH);

  // State and datapath registers; everything clears on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bank_q      <= '0;
      offset_q    <= '0;
      burst_cnt_q <= '0;
      load_pend_q <= 1'b0;
      pend_bank_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      offset_q    <= offset_d;
      burst_cnt_q <= burst_cnt_d;
      load_pend_q <= load_pend_d;
      pend_bank_q <= pend_bank_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // Returned beats go straight to the FIFO one cycle later, stale or not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q <= 1'b0;
    end else begin
      wr_en_q <= bus.rd_burst_data_valid;
    end
  end

  // Next-state and next-datapath decisions for the frame walk
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    offset_d    = offset_q;
    burst_cnt_d = burst_cnt_q;
    load_pend_d = load_pend_q;
    pend_bank_d = pend_bank_q;
    beat_cnt_d  = beat_cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.rd_load) begin
          bank_d      = bus.rd_bank;
          offset_d    = '0;
          burst_cnt_d = '0;
          state_d     = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (bus.rd_load) begin
          bank_d      = bus.rd_bank;
          offset_d    = '0;
          burst_cnt_d = '0;
        end else if (fifo_has_room) begin
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (bus.rd_load) begin
          load_pend_d = 1'b1;
          pend_bank_d = bus.rd_bank;
        end
        if (bus.rd_burst_ack) begin
          beat_cnt_d = '0;
          state_d    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (bus.rd_burst_data_valid && (beat_cnt_q < BEAT_MAX)) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (bus.rd_burst_finish) begin
          offset_d    = offset_q + OFF_STEP;
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (load_pend_q || bus.rd_load) begin
            bank_d      = bus.rd_load ? bus.rd_bank : pend_bank_q;
            offset_d    = '0;
            burst_cnt_d = '0;
            load_pend_d = 1'b0;
            state_d     = ST_CHECK;
          end else if (burst_cnt_q == LAST_BURST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CHECK;
          end
        end else if (bus.rd_load) begin
          load_pend_d = 1'b1;
          pend_bank_d = bus.rd_bank;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.rd_burst_req    = (state_q == ST_REQ);
  assign bus.rd_burst_addr   = {bank_q, offset_q};
  assign bus.rd_burst_len    = BURST_LEN_W'(BURST_LEN);
  assign bus.frame_read_done = (state_q == ST_DONE);
  assign bus.fifo_wr_en      = wr_en_q;

endmodule

// File: tb/tb_frame_read_ctrl.sv
// Bench for frame_read_ctrl with a small geometry: 4-word bursts,
// 3 bursts per frame, 16-word FIFO. A cycle table covers a full frame,
// the DONE reload and the FIFO threshold; hand sequences cover the long
// ack, the deferred reload, reload in CHECK and reset mid-burst; a random
// DDR/FIFO environment is checked against a burst-index frame model.
module tb_frame_read_ctrl;
  import ddr_frame_pkg::*;

  localparam int BANK_W       = 2;
  localparam int OFF_W        = 22;
  localparam int BURST_LEN    = 4;
  localparam int FRAME_BURSTS = 3;
  localparam int FIFO_AW      = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  frame_read_ctrl_if #(.BANK_W(BANK_W), .OFF_W(OFF_W), .FIFO_AW(FIFO_AW)) bus ();

  frame_read_ctrl #(
    .BANK_W(BANK_W), .OFF_W(OFF_W), .BURST_LEN(BURST_LEN),
    .FRAME_BURSTS(FRAME_BURSTS), .FIFO_AW(FIFO_AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          load;
    int          bank;
    int          level;
    int          ack;
    int          dv;
    int          fin;
    logic        ereq;
    logic [23:0] eaddr;
    logic        edone;
    logic        ewr;
  } vec_t;

  vec_t vecs[$];

  // Keeps a broken DUT from hanging the run
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [23:0] mk_addr(input int bank, input int idx);
    return {2'(bank), OFF_W'(idx * BURST_LEN)};
  endfunction

  task automatic check_bit(input string name, input logic actual, input logic expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%06h, expected 0x%06h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int load, input int bank, input int level,
                                input int ack, input int dv, input int fin);
    bus.rd_load             = 1'(load);
    bus.rd_bank             = 2'(bank);
    bus.fifo_wr_level       = 4'(level);
    bus.rd_burst_ack        = 1'(ack);
    bus.rd_burst_data_valid = 1'(dv);
    bus.rd_burst_finish     = 1'(fin);
  endtask

  task automatic apply_idle(input int level);
    apply_stimulus(0, 0, level, 0, 0, 0);
  endtask

  task automatic reset_dut();
    apply_idle(0);
    rst = 1'b1;
    #1;
    check_bit("reset_req", bus.rd_burst_req, 1'b0);
    check_bit("reset_done", bus.frame_read_done, 1'b0);
    check_bit("reset_wr_en", bus.fifo_wr_en, 1'b0);
    check_word("reset_addr", 32'(bus.rd_burst_addr), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int max_cycles, output logic found);
    found = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      if (bus.rd_burst_req) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) check_bit({tag, "_req_timeout"}, bus.rd_burst_req, 1'b1);
  endtask

  task automatic add_row(input int load, input int bank, input int level, input int ack,
                         input int dv, input int fin, input int ereq, input logic [23:0] eaddr,
                         input int edone, input int ewr);
    vec_t v;
    v.load = load; v.bank = bank; v.level = level; v.ack = ack; v.dv = dv; v.fin = fin;
    v.ereq = 1'(ereq); v.eaddr = eaddr; v.edone = 1'(edone); v.ewr = 1'(ewr);
    vecs.push_back(v);
  endtask

  // One burst starting from CHECK: request, ack after ack_dly, beats, finish
  task automatic add_burst(input int bank, input int idx, input int level, input int ack_dly,
                           input int beats, input int done_after);
    logic [23:0] a;
    a = mk_addr(bank, idx);
    add_row(0, 0, level, 0, 0, 0, 1, a, 0, 0);
    for (int k = 0; k < ack_dly; k++) add_row(0, 0, level, 0, 0, 0, 1, a, 0, 0);
    add_row(0, 0, level, 1, 0, 0, 0, 24'h0, 0, 0);
    for (int k = 0; k < beats; k++) add_row(0, 0, level, 0, 1, 0, 0, 24'h0, 0, 1);
    add_row(0, 0, level, 0, 0, 1, 0, 24'h0, done_after, 0);
  endtask

  task automatic build_table();
    add_row(1, 3, 0, 0, 0, 0, 0, 24'h0, 0, 0);
    add_burst(3, 0, 0, 2, 4, 0);
    add_burst(3, 1, 0, 2, 4, 0);
    add_burst(3, 2, 0, 2, 4, 1);
    add_row(0, 0, 0, 0, 0, 0, 0, 24'h0, 1, 0);
    add_row(0, 0, 0, 0, 0, 0, 0, 24'h0, 1, 0);
    add_row(1, 1, 0, 0, 0, 0, 0, 24'h0, 0, 0);
    add_burst(1, 0, 0, 0, 0, 0);
    add_row(0, 0, 15, 0, 0, 0, 0, 24'h0, 0, 0);
    add_row(0, 0, 13, 0, 0, 0, 0, 24'h0, 0, 0);
    add_row(0, 0, 13, 0, 0, 0, 0, 24'h0, 0, 0);
    add_burst(1, 1, 12, 1, 4, 0);
    add_burst(1, 2, 0, 0, 4, 1);
  endtask

  task automatic run_table();
    reset_dut();
    check_word("burst_len", 32'(bus.rd_burst_len), 32'd4);
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].load, vecs[i].bank, vecs[i].level,
                     vecs[i].ack, vecs[i].dv, vecs[i].fin);
      tick();
      check_bit($sformatf("vec%0d_req", i), bus.rd_burst_req, vecs[i].ereq);
      check_bit($sformatf("vec%0d_done", i), bus.frame_read_done, vecs[i].edone);
      check_bit($sformatf("vec%0d_wr_en", i), bus.fifo_wr_en, vecs[i].ewr);
      if (vecs[i].ereq)
        check_word($sformatf("vec%0d_addr", i), 32'(bus.rd_burst_addr), 32'(vecs[i].eaddr));
    end
    apply_idle(0);
  endtask

  // Serve one burst with level 0; optional rd_load at beat load_at (BURST_LEN = with finish)
  task automatic run_burst(input string tag, input logic [23:0] exp_addr, input int ack_dly,
                           input int load_at, input int load_bank, input logic exp_done);
    logic found;
    apply_idle(0);
    wait_req(tag, 40, found);
    if (found) begin
      check_word({tag, "_addr"}, 32'(bus.rd_burst_addr), 32'(exp_addr));
      for (int k = 0; k < ack_dly; k++) begin
        apply_idle(0);
        tick();
      end
      apply_stimulus(0, 0, 0, 1, 0, 0);
      tick();
      check_bit({tag, "_req_drop"}, bus.rd_burst_req, 1'b0);
      for (int k = 0; k < BURST_LEN; k++) begin
        apply_stimulus(int'(load_at == k), load_bank, 0, 0, 1, 0);
        tick();
      end
      apply_stimulus(int'(load_at == BURST_LEN), load_bank, 0, 0, 0, 1);
      tick();
      apply_idle(0);
      check_bit({tag, "_done"}, bus.frame_read_done, exp_done);
    end
  endtask

  task automatic seq_long_ack();
    logic found;
    int   extra_req;
    reset_dut();
    apply_stimulus(1, 2, 0, 0, 0, 0);
    tick();
    apply_idle(0);
    wait_req("long_ack", 10, found);
    check_word("long_ack_addr", 32'(bus.rd_burst_addr), 32'h800000);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_bit($sformatf("long_ack_hold%0d_req", k), bus.rd_burst_req, 1'b1);
      check_word($sformatf("long_ack_hold%0d_addr", k), 32'(bus.rd_burst_addr), 32'h800000);
    end
    apply_stimulus(0, 0, 0, 1, 0, 0);
    tick();
    check_bit("long_ack_req_drop", bus.rd_burst_req, 1'b0);
    for (int k = 0; k < BURST_LEN; k++) begin
      apply_stimulus(0, 0, 15, 0, 1, 0);
      tick();
    end
    apply_stimulus(0, 0, 15, 0, 0, 1);
    tick();
    extra_req = 0;
    for (int k = 0; k < 8; k++) begin
      apply_idle(15);
      tick();
      if (bus.rd_burst_req) extra_req++;
    end
    check_word("long_ack_extra_bursts", 32'(extra_req), 32'd0);
  endtask

  task automatic seq_load_in_wait();
    reset_dut();
    apply_stimulus(1, 3, 0, 0, 0, 0);
    tick();
    run_burst("lw_b0", 24'hC00000, 1, -1, 0, 1'b0);
    run_burst("lw_b1", 24'hC00004, 2, 1, 0, 1'b0);
    run_burst("lw_r0", 24'h000000, 0, -1, 0, 1'b0);
    run_burst("lw_r1", 24'h000004, 3, -1, 0, 1'b0);
    run_burst("lw_r2", 24'h000008, 1, -1, 0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_bit("lw_rst_done", bus.frame_read_done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic seq_overwrite_and_finish_load();
    reset_dut();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    tick();
    run_burst("ow_b0", 24'h000000, 0, 0, 3, 1'b0);
    run_burst("ow_b1", 24'hC00000, 0, BURST_LEN, 1, 1'b0);
    run_burst("ow_b2", 24'h400000, 0, -1, 0, 1'b0);
  endtask

  task automatic seq_load_in_check();
    logic found;
    reset_dut();
    apply_stimulus(1, 1, 15, 0, 0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      apply_idle(15);
      tick();
      check_bit($sformatf("chk_hold%0d_req", k), bus.rd_burst_req, 1'b0);
    end
    apply_stimulus(1, 2, 15, 0, 0, 0);
    tick();
    check_bit("chk_reload_req", bus.rd_burst_req, 1'b0);
    apply_idle(0);
    wait_req("chk", 10, found);
    check_word("chk_addr", 32'(bus.rd_burst_addr), 32'h800000);
  endtask

  task automatic seq_reset_mid_req();
    logic found;
    reset_dut();
    apply_stimulus(1, 3, 0, 0, 0, 0);
    tick();
    apply_idle(0);
    wait_req("rst_mid", 10, found);
    #2;
    rst = 1'b1;
    #1;
    check_bit("rst_mid_req", bus.rd_burst_req, 1'b0);
    check_bit("rst_mid_done", bus.frame_read_done, 1'b0);
    check_word("rst_mid_addr", 32'(bus.rd_burst_addr), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(0, 0, 0, 0, k % 2, int'(k == 3));
      tick();
      check_bit($sformatf("rst_stray%0d_req", k), bus.rd_burst_req, 1'b0);
      check_bit($sformatf("rst_stray%0d_wr_en", k), bus.fifo_wr_en, 1'(k % 2));
    end
    apply_stimulus(1, 1, 0, 0, 0, 0);
    tick();
    apply_idle(0);
    wait_req("rst_reload", 10, found);
    check_word("rst_reload_addr", 32'(bus.rd_burst_addr), 32'h400000);
  endtask

  // Random DDR/FIFO environment against a frame model kept as (bank, burst index)
  task automatic random_test(input int n_cycles);
    int          m_bank, m_idx, m_pend_bank;
    logic        m_pend, m_done;
    int          phase, dly, beats_left, idle_cnt, hold;
    logic        first_wait, prev_dv;
    logic [23:0] req_addr;
    int          load, bank, ack, dv, fin, level;

    reset_dut();
    m_bank = $urandom_range(0, 3);
    m_idx = 0; m_pend = 1'b0; m_pend_bank = 0; m_done = 1'b0;
    phase = 0; dly = 0; beats_left = 0; idle_cnt = 0; hold = 0;
    first_wait = 1'b0; req_addr = '0;
    apply_stimulus(1, m_bank, 0, 0, 0, 0);
    tick();
    prev_dv = 1'b0;

    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      check_bit("rand_wr_en", bus.fifo_wr_en, prev_dv);
      check_bit("rand_done", bus.frame_read_done, m_done);
      check_bit("rand_done_and_req", bus.frame_read_done & bus.rd_burst_req, 1'b0);

      load = 0; bank = 0; ack = 0; dv = 0; fin = 0;
      level = $urandom_range(0, 15);

      if (phase == 0) begin
        if (bus.rd_burst_req) begin
          check_word("rand_addr", 32'(bus.rd_burst_addr), 32'(mk_addr(m_bank, m_idx)));
          req_addr = bus.rd_burst_addr;
          dly = $urandom_range(0, 4);
          idle_cnt = 0;
          phase = 1;
        end else begin
          idle_cnt++;
          if (idle_cnt > 60) begin
            check_bit("rand_req_timeout", bus.rd_burst_req, 1'b1);
            break;
          end
        end
      end

      if (phase == 1) begin
        check_bit("rand_req_hold", bus.rd_burst_req, 1'b1);
        check_word("rand_addr_hold", 32'(bus.rd_burst_addr), 32'(req_addr));
        if ($urandom_range(0, 7) == 0) begin
          load = 1; bank = $urandom_range(0, 3);
          m_pend = 1'b1; m_pend_bank = bank;
        end
        if (dly == 0) begin
          ack = 1;
          beats_left = ($urandom_range(0, 7) == 0) ? $urandom_range(0, BURST_LEN - 1) : BURST_LEN;
          first_wait = 1'b1;
          phase = 2;
        end else begin
          dly--;
        end
      end else if (phase == 2) begin
        if (first_wait) begin
          check_bit("rand_req_drop", bus.rd_burst_req, 1'b0);
          first_wait = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) begin
          load = 1; bank = $urandom_range(0, 3);
          m_pend = 1'b1; m_pend_bank = bank;
        end
        if (beats_left == 0) begin
          fin = 1;
          if (m_pend) begin
            m_bank = m_pend_bank; m_idx = 0; m_pend = 1'b0;
          end else begin
            m_idx++;
            if (m_idx == FRAME_BURSTS) m_done = 1'b1;
          end
          if (m_done) begin
            hold = $urandom_range(1, 5);
            phase = 3;
          end else begin
            phase = 0;
          end
        end else if ($urandom_range(0, 3) != 0) begin
          dv = 1;
          beats_left--;
        end
      end else if (phase == 3) begin
        check_bit("rand_done_req", bus.rd_burst_req, 1'b0);
        if (hold == 0) begin
          load = 1; bank = $urandom_range(0, 3);
          m_bank = bank; m_idx = 0; m_done = 1'b0;
          phase = 0;
        end else begin
          hold--;
        end
      end

      apply_stimulus(load, bank, level, ack, dv, fin);
      tick();
      prev_dv = 1'(dv);
    end
    apply_idle(0);
  endtask

  initial begin
    apply_idle(0);
    $display("[TB] frame_read_ctrl bench starting");
    build_table();
    run_table();
    seq_long_ack();
    seq_load_in_wait();
    seq_overwrite_and_finish_load();
    seq_load_in_check();
    seq_reset_mid_req();
    random_test(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
